mem_stage_dmem: RTL and testbench

// - MEM-stage data memory with multi-cycle access: performs loads and stores for the

---
 rtl/mem_stage_dmem.sv | 107 ++++++++++
 tb/tb_mem_stage_dmem.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_dmem.sv
// MEM-stage data memory with a fixed multi-cycle access latency.
// Holds the pipeline with stall_o until the load/store has committed.
module mem_stage_dmem #(
  parameter int ADDR_W = 8,
  parameter int LAT    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MEM_MemRead_i,
  input  logic        MEM_MemWrite_i,
  input  logic [31:0] MEM_Addr_i,
  input  logic [31:0] MEM_WriteData_i,
  output logic [31:0] MEM_MemOut_o,
  output logic        stall_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, next_state;
  logic [3:0]        cnt, next_cnt;
  logic              stall;
  logic              commit;
  logic              req;
  logic              aligned;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       mem [2**ADDR_W];
  logic              unused_addr;

  assign req         = MEM_MemRead_i | MEM_MemWrite_i;
  assign aligned     = (MEM_Addr_i[1:0] == 2'b00);
  assign idx         = MEM_Addr_i[ADDR_W+1:2];
  assign unused_addr = ^MEM_Addr_i[31:ADDR_W+2];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // commit marks the edge that enters DONE; that is where the access happens
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    stall      = 1'b0;
    commit     = 1'b0;
    unique case (state)
      IDLE: begin
        if (req && aligned) begin
          stall = 1'b1;
          if (LAT == 1) begin
            next_state = DONE;
            commit     = 1'b1;
          end else begin
            next_state = BUSY;
            next_cnt   = 4'(LAT - 1);
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt == 4'd1) begin
          next_state = DONE;
          next_cnt   = 4'd0;
          commit     = 1'b1;
        end else begin
          next_cnt = cnt - 4'd1;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
        next_cnt   = 4'd0;
      end
    endcase
  end

  assign stall_o = stall & rst_i;

  // The array is never cleared; holding rst_i low drops any pending store
  always_ff @(posedge clk_i) begin
    if (rst_i && commit && MEM_MemWrite_i) begin
      mem[idx] <= MEM_WriteData_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      MEM_MemOut_o <= 32'd0;
      misalign_o   <= 1'b0;
    end else begin
      if (commit && MEM_MemRead_i && !MEM_MemWrite_i) begin
        MEM_MemOut_o <= mem[idx];
      end
      if (req && !aligned) begin
        misalign_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_dmem.sv
// Randomized self-checking bench for mem_stage_dmem against a word-array model
// of the memory plus expected load-output and misalign-flag state.
module tb_mem_stage_dmem;

  localparam int ADDR_W = 8;
  localparam int LAT    = 2;
  localparam int DEPTH  = 2**ADDR_W;

  logic        clk_i;
  logic        rst_i;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_out;
  logic        stall;
  logic        misalign;

  int          errors;
  int          checks;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_out;
  logic        exp_mis;
  logic [15:0] trace;

  mem_stage_dmem #(.ADDR_W(ADDR_W), .LAT(LAT)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .MEM_MemRead_i  (mem_read),
    .MEM_MemWrite_i (mem_write),
    .MEM_Addr_i     (mem_addr),
    .MEM_WriteData_i(mem_wdata),
    .MEM_MemOut_o   (mem_out),
    .stall_o        (stall),
    .misalign_o     (misalign)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called right after a rising edge; runs one instruction through the stage
  task automatic apply_stimulus(input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [31:0] data);
    int   n;
    bit   done;
    int   word;
    logic is_req;
    logic is_aligned;
    mem_read   = rd;
    mem_write  = wr;
    mem_addr   = addr;
    mem_wdata  = data;
    is_req     = rd | wr;
    is_aligned = (addr % 4) == 0;
    word       = int'((addr / 4) % DEPTH);
    if (is_req && is_aligned) begin
      n    = 0;
      done = 0;
      while (!done && n < LAT + 4) begin
        @(negedge clk_i);
        trace = {trace[14:0], stall};
        if (stall) n++;
        else done = 1;
      end
      check_output("stall_cycles", 32'(n), 32'(LAT));
      check_output("done_reached", 32'(done), 32'd1);
      if (wr) model_mem[word] = data;
      else    exp_out = model_mem[word];
      check_output("done_memout", mem_out, exp_out);
      @(posedge clk_i);
      #1;
    end else begin
      @(negedge clk_i);
      trace = {trace[14:0], stall};
      check_output("nostall", 32'(stall), 32'd0);
      @(posedge clk_i);
      #1;
      if (is_req) exp_mis = 1'b1;
      check_output("memout_hold", mem_out, exp_out);
    end
    check_output("misalign", 32'(misalign), 32'(exp_mis));
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    trace     = '0;
    exp_out   = 32'd0;
    exp_mis   = 1'b0;
    rst_i     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_output("reset_stall", 32'(stall), 32'd0);
    check_output("reset_memout", mem_out, 32'd0);
    check_output("reset_misalign", 32'(misalign), 32'd0);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    // give every word a known value so any later load has a defined answer
    for (int i = 0; i < DEPTH; i++) begin
      apply_stimulus(1'b0, 1'b1, 32'(i * 4), 32'(i) * 32'h0101_0101 ^ 32'h5A00_00C3);
    end

    apply_stimulus(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    apply_stimulus(1'b1, 1'b0, 32'h10, 32'h0);
    check_output("load_deadbeef", mem_out, 32'hDEAD_BEEF);

    trace = '0;
    apply_stimulus(1'b0, 1'b1, 32'h20, 32'h1234_5678);
    apply_stimulus(1'b1, 1'b0, 32'h20, 32'h0);
    check_output("stall_pattern", 32'(trace[5:0]), 32'b110110);
    check_output("store_load", mem_out, 32'h1234_5678);

    apply_stimulus(1'b1, 1'b1, 32'h8, 32'hA5A5_A5A5);
    check_output("both_memout", mem_out, 32'h1234_5678);
    apply_stimulus(1'b1, 1'b0, 32'h8, 32'h0);
    check_output("both_stored", mem_out, 32'hA5A5_A5A5);

    apply_stimulus(1'b1, 1'b0, 32'h6, 32'h0);
    check_output("misalign_set", 32'(misalign), 32'd1);
    apply_stimulus(1'b1, 1'b0, 32'h10, 32'h0);
    check_output("misalign_sticky", 32'(misalign), 32'd1);

    apply_stimulus(1'b0, 1'b1, 32'h400, 32'h1);
    apply_stimulus(1'b1, 1'b0, 32'h0, 32'h0);
    check_output("wrap_load", mem_out, 32'h1);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, $urandom, $urandom);

    // reset in the middle of a store's BUSY phase: the store must be lost
    mem_read  = 1'b0;
    mem_write = 1'b1;
    mem_addr  = 32'h10;
    mem_wdata = 32'h1111_1111;
    @(posedge clk_i);
    @(negedge clk_i);
    check_output("busy_stall", 32'(stall), 32'd1);
    rst_i     = 1'b0;
    mem_write = 1'b0;
    #1;
    check_output("midreset_stall", 32'(stall), 32'd0);
    check_output("midreset_memout", mem_out, 32'd0);
    check_output("midreset_misalign", 32'(misalign), 32'd0);
    exp_out = 32'd0;
    exp_mis = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check_output("release_stall", 32'(stall), 32'd0);
    @(posedge clk_i);
    #1;
    apply_stimulus(1'b1, 1'b0, 32'h10, 32'h0);
    check_output("store_abandoned", mem_out, 32'hDEAD_BEEF);

    for (int i = 0; i < 300; i++) begin
      int          k;
      logic [31:0] a;
      k = $urandom_range(0, 9);
      a = $urandom & 32'hFFFF_FFFC;
      case (k)
        0, 1:    apply_stimulus(1'b0, 1'b0, $urandom, $urandom);
        2, 3, 4: apply_stimulus(1'b1, 1'b0, a, $urandom);
        5, 6, 7: apply_stimulus(1'b0, 1'b1, a, $urandom);
        8:       apply_stimulus(1'b1, 1'b1, a, $urandom);
        default: apply_stimulus($urandom_range(0, 1) == 1, 1'b1,
                                a | 32'($urandom_range(1, 3)), $urandom);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
